// File: rtl/fs_serial_nb.sv
// Digit-serial full subtractor: diff = a - b - bin, DIGIT bits per clock with a registered borrow chain.
// Optional signed-overflow flag is built when FS_SIGNED_OVF_EN is defined; otherwise ovf is tied low.
module fs_serial_nb #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bar,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             brw;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic [WIDTH-1:0] wres;
    logic [WIDTH-1:0] res_next;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d;
    logic             bo;

    // Digit select and write-back use constant slices per digit so the mux stays index-width clean.
    always_comb begin
        a_dig    = '0;
        b_dig    = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (k == KW'(i)) begin
                a_dig = wa[i*DIGIT +: DIGIT];
                b_dig = wb[i*DIGIT +: DIGIT];
            end
        end
        {bo, d}  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw};
        res_next = wres;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (k == KW'(i)) begin
                res_next[i*DIGIT +: DIGIT] = d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            brw   <= 1'b0;
            wa    <= '0;
            wb    <= '0;
            wres  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bar   <= 1'b0;
`ifdef FS_SIGNED_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        wa    <= a;
                        wb    <= b;
                        brw   <= bin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    wres <= res_next;
                    brw  <= bo;
                    k    <= k + 1'b1;
                    if (k == KLAST) begin
                        k     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_next;
                        bar   <= bo;
`ifdef FS_SIGNED_OVF_EN
                        ovf   <= (wa[WIDTH-1] != wb[WIDTH-1]) && (res_next[WIDTH-1] != wa[WIDTH-1]);
`endif
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef FS_SIGNED_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fs_serial_nb.sv
// Self-checking bench for fs_serial_nb: scoreboard of flat-subtraction results, two parameter sets.
module tb_fs_serial_nb;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        bin   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy, done, bar, ovf;
    logic [15:0] diff;

    logic        start8 = 1'b0;
    logic        bin8   = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8, done8, bar8, ovf8;
    logic [7:0]  diff8;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] q[$];
    logic [9:0]  q8[$];
    logic [15:0] last_diff = '0;

    fs_serial_nb #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bar(bar), .ovf(ovf)
    );

    fs_serial_nb #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bar(bar8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Flat reference: {ovf, bar, diff}
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] r;
        logic        o;
        r = {1'b0, x} - {1'b0, y} - {16'b0, ci};
`ifdef FS_SIGNED_OVF_EN
        o = (x[15] != y[15]) && (r[15] != x[15]);
`else
        o = 1'b0;
`endif
        return {o, r[16], r[15:0]};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] r;
        logic       o;
        r = {1'b0, x} - {1'b0, y} - {8'b0, ci};
`ifdef FS_SIGNED_OVF_EN
        o = (x[7] != y[7]) && (r[7] != x[7]);
`else
        o = 1'b0;
`endif
        return {o, r[8], r[7:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name);
        logic [17:0] e;
        if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: done seen with empty scoreboard", name);
            return;
        end
        e = q.pop_front();
        n_checks++;
        if (diff !== e[15:0]) begin
            n_fail++;
            $display("FAIL %s diff: got %h expected %h", name, diff, e[15:0]);
        end
        n_checks++;
        if (bar !== e[16]) begin
            n_fail++;
            $display("FAIL %s bar: got %b expected %b", name, bar, e[16]);
        end
        n_checks++;
        if (ovf !== e[17]) begin
            n_fail++;
            $display("FAIL %s ovf: got %b expected %b", name, ovf, e[17]);
        end
        last_diff = e[15:0];
    endtask

    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic ci, input bit push);
        a = x; b = y; bin = ci; start = 1'b1;
        if (push) q.push_back(model16(x, y, ci));
        tick;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got %b expected 1", busy);
        end
    endtask

    task automatic wait_done(input string name, input int exp_ticks);
        int n = 0;
        while (1) begin
            tick;
            n++;
            if (done === 1'b1) break;
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_run: got %b expected 1 at tick %0d", name, busy, n);
            end
            if (n >= 30) begin
                n_checks++; n_fail++;
                $display("FAIL %s timeout: no done after %0d cycles", name, n);
                return;
            end
        end
        n_checks++;
        if (n != exp_ticks) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, exp_ticks);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_done: got %b expected 0", name, busy);
        end
        check_result(name);
        tick;
        n_checks++;
        if (done !== 1'b0 || diff !== last_diff) begin
            n_fail++;
            $display("FAIL %s pulse_hold: done %b diff %h expected done 0 diff %h", name, done, diff, last_diff);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_checks++;
        if ({busy, done, bar, ovf} !== 4'b0 || diff !== 16'h0) begin
            n_fail++;
            $display("FAIL reset16: busy %b done %b bar %b ovf %b diff %h expected all 0", busy, done, bar, ovf, diff);
        end
        n_checks++;
        if ({busy8, done8, bar8, ovf8} !== 4'b0 || diff8 !== 8'h0) begin
            n_fail++;
            $display("FAIL reset8: busy %b done %b bar %b ovf %b diff %h expected all 0", busy8, done8, bar8, ovf8, diff8);
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b done %b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        start_op(16'h1234, 16'h0234, 1'b0, 1'b1);
        wait_done("basic", 4);
    endtask

    task automatic test_borrow;
        start_op(16'h0000, 16'h0001, 1'b0, 1'b1);
        wait_done("borrow_zero", 4);
        start_op(16'h0005, 16'h0005, 1'b1, 1'b1);
        wait_done("borrow_bin", 4);
    endtask

    task automatic test_overflow;
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done("overflow", 4);
        start_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        wait_done("overflow_pos", 4);
    endtask

    task automatic test_ignore_and_abort;
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b1);
        tick;
        a = 16'hAAAA; b = 16'h1111; bin = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done("ignore_start", 2);
        tick;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_requeue: busy %b expected 0", busy);
        end
        start_op(16'h4321, 16'h0001, 1'b0, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        last_diff = 16'h0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || bar !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: busy %b done %b diff %h bar %b ovf %b expected 0 0 0000 0 0", busy, done, diff, bar, ovf);
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet: done %b busy %b expected 0 0 at cycle %0d", done, busy, i);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [32:0] ops [3];
        ops[0] = {16'h1111, 16'h0222, 1'b0};
        ops[1] = {16'h0003, 16'h0004, 1'b1};
        ops[2] = {16'hFFFF, 16'h7FFF, 1'b1};
        {a, b, bin} = ops[0];
        start = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            q.push_back(model16(ops[i][32:17], ops[i][16:1], ops[i][0]));
            if (i < 2) {a, b, bin} = ops[i+1];
            else start = 1'b0;
            for (int t = 1; t <= 4; t++) begin
                tick;
                if (t < 4) begin
                    n_checks++;
                    if (done !== 1'b0 || diff !== last_diff) begin
                        n_fail++;
                        $display("FAIL b2b_stable op%0d t%0d: done %b diff %h expected 0 %h", i, t, done, diff, last_diff);
                    end
                end else begin
                    n_checks++;
                    if (done !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_done op%0d: done %b expected 1", i, done);
                    end
                    check_result("b2b");
                end
            end
            if (i < 2) begin
                tick;
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_restart op%0d: done %b busy %b expected 0 1", i, done, busy);
                end
            end
        end
        tick;
    endtask

    task automatic test_width8;
        logic [16:0] vec [2];
        logic [9:0]  e;
        int          n;
        vec[0] = {8'h00, 8'hFF, 1'b1};
        vec[1] = {8'h80, 8'h01, 1'b0};
        for (int i = 0; i < 2; i++) begin
            {a8, b8, bin8} = vec[i];
            q8.push_back(model8(vec[i][16:9], vec[i][8:1], vec[i][0]));
            start8 = 1'b1;
            tick;
            start8 = 1'b0;
            n = 0;
            while (done8 !== 1'b1 && n < 30) begin
                tick;
                n++;
            end
            n_checks++;
            if (n != 8) begin
                n_fail++;
                $display("FAIL w8 latency v%0d: got %0d expected 8", i, n);
            end
            e = q8.pop_front();
            n_checks++;
            if (diff8 !== e[7:0] || bar8 !== e[8] || ovf8 !== e[9]) begin
                n_fail++;
                $display("FAIL w8 result v%0d: diff %h bar %b ovf %b expected %h %b %b", i, diff8, bar8, ovf8, e[7:0], e[8], e[9]);
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow;
        test_overflow;
        test_ignore_and_abort;
        test_back_to_back;
        test_width8;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results never produced, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fs_serial_nb.md
# fs_serial_nb

Parametrised digit-serial full subtractor. Computes `diff = a - b - bin` over `WIDTH` bits, processing `DIGIT` bits per clock with a registered borrow chain. This trades latency for area against the flat ripple subtractors. It sits as a shared arithmetic unit behind a start/done handshake, used wherever wide subtraction is needed without a full-width combinational borrow path.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width.
- `DIGIT`, default 4: bits processed per cycle.
  - `WIDTH % DIGIT` must be 0.
  - `NDIG = WIDTH/DIGIT` is the number of digit cycles.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when not busy.
- `a` input WIDTH: minuend, captured on accepted start.
- `b` input WIDTH: subtrahend, captured on accepted start.
- `bin` input 1: borrow in, captured on accepted start.
- `busy` output 1: high while digits are being processed.
- `done` output 1: one-cycle pulse when a result is written.
- `diff` output WIDTH: result, held until the next result.
- `bar` output 1: borrow out of the MSB, held with `diff`.
- `ovf` output 1: signed overflow, held with `diff`; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, `start=1`:
  - Capture `a`, `b`, `bin` into working registers.
  - Clear the digit counter.
  - Go to RUN.
- DONE, `start=0`: go to IDLE.
- RUN, each cycle:
  - Compute `{bo, d} = a_dig[k] - b_dig[k] - brw`, where `k` is the counter and `brw` is the internal borrow.
  - `d` is `DIGIT` bits; `bo` is 1 bit.
  - Store `d` into working result bits `[k*DIGIT +: DIGIT]`.
  - Set `brw <= bo` and `k <= k+1`.
- RUN, when `k == NDIG-1`:
  - Go to DONE.
  - Load `diff` from the working result and `bar` from the final `bo`.
  - Load `ovf`.
- `start` in RUN is ignored; no queueing, no error.
- `diff`, `bar` and `ovf` change only on the RUN→DONE transition. Working registers are internal and never visible.
- Arithmetic is modulo 2^WIDTH.
  - `bar = 1` iff `a < b + bin` (unsigned).
  - Result is identical to a flat `{bar, diff} = a - b - bin`.
- Reset mid-operation aborts the computation: no `done`, and outputs are cleared.

## Timing
- Reset values:
  - `busy=0`, `done=0`, `diff=0`, `bar=0`, `ovf=0`.
  - State IDLE, counter 0, internal borrow 0.
- `start` accepted at edge E0: `busy=1` after E0.
- Digits are processed at edges E1..E(NDIG).
- After E(NDIG):
  - State DONE, `busy=0`, `done=1`.
  - `diff`, `bar` and `ovf` are valid.
- Latency is NDIG+1 edges from start sample to result visible.
- `done` is high exactly one cycle.
- `start=1` in DONE begins a new operation:
  - `busy=1` next cycle, `done=0`.
  - Back-to-back throughput is one result per NDIG+1 cycles.
- `rst` dominates `start` on the same edge.

## Configuration
- Macro: `FS_SIGNED_OVF_EN`.
- Defined: on the RUN→DONE transition, load `ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])`. This uses the captured operands and is the two's-complement overflow of `a - b - bin`.
- Undefined:
  - The overflow logic is not built.
  - `ovf` is tied to 0.
  - The port is still present.

## Test plan
- WIDTH=16, DIGIT=4: `a=0x1234`, `b=0x0234`, `bin=0`, start at E0 -> `busy` high E0..E4, `done` pulse after E4, `diff=0x1000`, `bar=0`.
- `a=0x0000`, `b=0x0001`, `bin=0` -> `diff=0xFFFF`, `bar=1`; then `a=5`, `b=5`, `bin=1` -> `diff=0xFFFF`, `bar=1`.
- `a=0x8000`, `b=0x0001`, `bin=0` -> `diff=0x7FFF`, `bar=0`; `ovf=1` with `FS_SIGNED_OVF_EN`, `ovf=0` without.
- Start `a=0x00FF`, `b=0x0001`; pulse `start` with different operands at E2 -> ignored, `diff=0x00FE` after E4. Then start again with `rst` at E2 -> `busy=0`, `diff=0`, no `done` pulse.
- `start` held high continuously -> results every 5 cycles, `done` pulses never adjacent, outputs stable between pulses.
- WIDTH=8, DIGIT=1: `a=0x00`, `b=0xFF`, `bin=1` -> `done` after E8, `diff=0x00`, `bar=1`.
